// File: rtl/rv32m_divider.sv
// rv32m_divider: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Signed operands are reduced to magnitudes, divided over XLEN cycles and
// sign-corrected at the end. Divide-by-zero and signed overflow finish in
// one cycle. Shares the start/fin handshake of the shift-add multiplier.
//
// state | meaning
// IDLE  | waiting for start; result holds the last completed value
// DIV   | one restoring step per cycle, counter counts XLEN down to 0
// DONE  | fin pulse, result valid; start is ignored here
module rv32m_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            fin,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] rem, quo, dvs_mag;
  logic [CW-1:0]   count;
  logic            rem_op, neg_q, neg_r;

  // op[2] only distinguishes MUL/DIV groups upstream; it carries no meaning here.
  logic            unused_op;
  assign unused_op = op[2];

  logic            is_signed, is_rem, dvd_neg, dvs_neg;
  logic            div_zero, overflow, fast, accept;
  logic [XLEN-1:0] dvd_mag_in, dvs_mag_in, fast_result;
  logic [XLEN:0]   rem_shift, trial;
  logic [XLEN-1:0] quo_step, rem_step, final_result;
  logic            last;

  // Operand decode and fast-path detection, evaluated on the accept edge.
  always_comb begin
    is_signed   = ~op[0];
    is_rem      = op[1];
    dvd_neg     = is_signed & dividend[XLEN-1];
    dvs_neg     = is_signed & divisor[XLEN-1];
    dvd_mag_in  = dvd_neg ? -dividend : dividend;
    dvs_mag_in  = dvs_neg ? -divisor : divisor;
    div_zero    = (divisor == '0);
    overflow    = is_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (divisor == '1);
    fast        = div_zero | overflow;
    accept      = (state == IDLE) & start;
    fast_result = '0;
    if (div_zero)
      fast_result = is_rem ? dividend : '1;
    else if (!is_rem)
      fast_result = dividend;
  end

  // One restoring step; the trial is XLEN+1 bits so the borrow is the sign.
  always_comb begin
    rem_shift    = {rem, quo[XLEN-1]};
    trial        = rem_shift - {1'b0, dvs_mag};
    quo_step     = {quo[XLEN-2:0], ~trial[XLEN]};
    rem_step     = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
    last         = (count == CW'(1));
    final_result = rem_op ? (neg_r ? -rem_step : rem_step)
                          : (neg_q ? -quo_step : quo_step);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = fast ? DONE : DIV;
      DIV: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= '0;
      quo     <= '0;
      dvs_mag <= '0;
      count   <= '0;
      rem_op  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      rem_op  <= is_rem;
      neg_q   <= dvd_neg ^ dvs_neg;
      neg_r   <= dvd_neg;
      dvs_mag <= dvs_mag_in;
      rem     <= '0;
      quo     <= dvd_mag_in;
      count   <= CW'(XLEN);
      if (fast) result <= fast_result;
    end else if (state == DIV) begin
      rem   <= rem_step;
      quo   <= quo_step;
      count <= count - CW'(1);
      if (last) result <= final_result;
    end
  end

endmodule

// File: tb/tb_rv32m_divider.sv
// tb_rv32m_divider: directed vector table plus handshake corner sequences.
module tb_rv32m_divider;

  logic        clk = 1'b0;
  logic        rst, start, busy, fin;
  logic [2:0]  op;
  logic [31:0] dividend, divisor, result;
  int          checks = 0;
  int          failures = 0;

  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  rv32m_divider #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .fin(fin), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after fin.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = 32'hDEAD_BEEF; divisor = 32'h1234_5678;
    n = 1;
    chk($sformatf("%s_busy", name), 32'(busy), 32'd1);
    while (!fin && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s_lat", name), 32'(n), 32'(lat));
    chk($sformatf("%s_result", name), result, exp);
    @(negedge clk);
    chk($sformatf("%s_fin_once", name), 32'(fin), 32'd0);
  endtask

  initial begin
    int n, fins;
    logic [31:0] res_at_fin;

    vecs[0]  = '{"divu_100_7",   OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{"remu_100_7",   OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{"rem_7_m2",     OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[5]  = '{"divu_big_2",   OP_DIVU, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  33};
    vecs[6]  = '{"divu_5_0",     OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{"div_5_0",      OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[8]  = '{"rem_m10_0",    OP_REM,  32'hFFFF_FFF6,  32'd0,          32'hFFFF_FFF6,  1};
    vecs[9]  = '{"remu_5_0",     OP_REMU, 32'd5,          32'd0,          32'd5,          1};
    vecs[10] = '{"div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[11] = '{"rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[12] = '{"div_m8_m2",    OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          33};
    vecs[13] = '{"rem_m6_3",     OP_REM,  32'hFFFF_FFFA,  32'd3,          32'd0,          33};
    vecs[14] = '{"remu_max_hi",  OP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  33};
    vecs[15] = '{"divu_op2clr",  3'b001,  32'd100,        32'd7,          32'd14,         33};

    rst = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_fin", 32'(fin), 32'd0);
    chk("reset_result", result, 32'd0);

    for (int i = 0; i < 16; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Reset in the middle of an operation.
    op = OP_DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_fin", 32'(fin), 32'd0);
    chk("rstmid_result", result, 32'd0);
    fins = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fin) fins++;
    end
    chk("rstmid_no_fin", 32'(fins), 32'd0);
    run_op("after_rst_divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Start pulsed while busy must be dropped.
    op = OP_DIVU; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 32'd8; divisor = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fins = 0; res_at_fin = '0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (fin) begin
        fins++;
        res_at_fin = result;
      end
    end
    chk("busy_start_fin_count", 32'(fins), 32'd1);
    chk("busy_start_result", res_at_fin, 32'd10);
    chk("result_holds_idle", result, 32'd10);
    run_op("after_busy_divu_8_2", OP_DIVU, 32'd8, 32'd2, 32'd4, 33);

    // start held high: DONE ignores it, the following IDLE cycle re-accepts.
    op = OP_DIVU; dividend = 32'd20; divisor = 32'd4; start = 1'b1;
    @(negedge clk);
    dividend = 32'd40;
    n = 1;
    while (!fin && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("held_first_lat", 32'(n), 32'd33);
    chk("held_first_result", result, 32'd5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fin && n < 60);
    start = 1'b0;
    chk("held_second_spacing", 32'(n), 32'd34);
    chk("held_second_result", result, 32'd10);
    @(negedge clk);
    chk("held_end_fin", 32'(fin), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32m_divider.md
Name: rv32m_divider

Overview:
- Iterative restoring divider for the RV32M DIV, DIVU, REM and REMU instructions.
- It is the inverse companion of the shift-add multiplier. It sits beside that multiplier in the M-extension execute path and uses the same start/fin handshake.
- Signed operands are converted to magnitudes, divided unsigned over XLEN cycles, then the result sign is corrected.
- Divide-by-zero and signed overflow take a 1-cycle fast path.

Parameters:
XLEN, 32, operand/result width; counter width is clog2(XLEN)+1

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only in IDLE
op  input  3  RV32M funct3; only op[1:0] decoded: 00 DIV, 01 DIVU, 10 REM, 11 REMU; op[2] ignored
dividend  input  XLEN  rs1 value; sampled with start
divisor  input  XLEN  rs2 value; sampled with start
busy  output  1  high in DIV and DONE states
fin  output  1  one-cycle pulse; result valid
result  output  XLEN  quotient or remainder per op

Behaviour:
- Reset (sync, rst high at clk edge, overrides everything including mid-operation):
  - state=IDLE, fin=0, busy=0, result=0, internal quotient/remainder/counter=0.
- States:
  - IDLE: wait for start.
  - DIV: iterating.
  - DONE: fin=1 for exactly one cycle, then IDLE.
- Accept, at the edge where state=IDLE and start=1:
  - Latch op, dividend, divisor.
  - signed = ~op[0].
  - neg_q = signed & (dividend[XLEN-1] ^ divisor[XLEN-1]).
  - neg_r = signed & dividend[XLEN-1].
  - Magnitudes: two's complement of the operand when signed and MSB set; otherwise raw.
- Fast path on the accept edge. result is loaded immediately and state goes straight to DONE (fin visible 1 cycle after accept):
  - divisor==0: quotient ops return all-ones (0xFFFFFFFF); remainder ops return dividend unchanged, signed or not.
  - Signed overflow, dividend==0x80000000 and divisor==0xFFFFFFFF with op DIV: result 0x80000000. With op REM: result 0.
- Normal path:
  - Load rem=0, quo=|dividend|, counter=XLEN; go to DIV.
  - Each DIV edge does one restoring step:
    - {rem,quo} shifted left 1.
    - trial = rem_shifted - |divisor| (XLEN+1 bits).
    - If trial non-negative: rem=trial, quo LSB=1. Else quo LSB=0.
    - counter decrements.
  - On the edge where counter goes 1->0: load result, state->DONE.
    - result = quotient ops: neg_q ? -quo : quo; remainder ops: neg_r ? -rem : rem.
  - Latency: exactly XLEN+1 cycles from the accept edge to the fin cycle (33 for XLEN=32).
- Sign rules:
  - Quotient truncates toward zero.
  - Remainder sign follows dividend.
  - A zero remainder is never negated into a nonzero value.
- result holds its value after fin until the next accepted start's completion. It is not cleared in IDLE.
- start while busy=1 is ignored; no queuing.
- start high in the DONE cycle is ignored. start held high continuously re-triggers on the first IDLE cycle.
- Inputs need only be stable on the accept edge; later changes have no effect.
- fin never asserts without a prior accept. Back-to-back operations: minimum spacing is 1 IDLE cycle between fin and the next accept.

Test Plan:
- DIVU 100/7, start 1 cycle -> busy=1 next cycle; fin pulses exactly 33 cycles after the accept edge; result=14. Repeat with REMU -> result=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM same operands -> 0xFFFFFFFF (-1). REM 7 / 0xFFFFFFFE (-2) -> 1. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Divide by zero, DIVU 5/0 and DIV 5/0 -> 0xFFFFFFFF; REM 0xFFFFFFF6/0 -> 0xFFFFFFF6. In all cases fin 1 cycle after accept.
- Overflow, DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. fin 1 cycle after accept.
- Reset mid-op: accept DIVU 1000/3, assert rst at cycle 10 -> next cycle busy=0, fin=0, result=0, and no fin ever appears. A new DIVU 9/3 then completes with 3 after 33 cycles.
- Start during busy: accept DIVU 50/5, pulse start with 8/2 at cycle 5 -> one fin only, result=10. The next start in IDLE is processed normally.
